// File: rtl/lsu_if.sv
// Core-side request/response and data-memory bus signals of the load/store unit.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        MemWr;
   logic [2:0]  MemOP;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_err;

   // slave: the LSU itself; master: the surrounding core and data memory
   modport slave (
      input  req_valid, addr, wdata, MemWr, MemOP, resp_ready,
             mem_gnt, mem_rvalid, mem_rdata, mem_err,
      output req_ready, resp_valid, rdata, err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output req_valid, addr, wdata, MemWr, MemOP, resp_ready,
             mem_gnt, mem_rvalid, mem_rdata, mem_err,
      input  req_ready, resp_valid, rdata, err,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: store lane formatting, load extraction, req/gnt/rvalid bus with timeout.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 9
) (
   input logic  clk,
   input logic  rst,
   lsu_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_r;
   logic [1:0]       off_r;
   logic             we_r;
   logic             accept;
   logic             misalign;
   logic             timeout_hit;
   logic [31:0]      rsp_data;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
             (op == 3'b100) || (op == 3'b101);
   endfunction

   function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] o);
      case (sz)
         2'b00:   return 4'b0001 << o;
         2'b01:   return o[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
      case (sz)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] o,
                                                input logic [31:0] word);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = word[{o, 3'b000} +: 8];
      h = o[1] ? word[31:16] : word[15:0];
      case (op)
         3'b000:  return 32'(b);
         3'b100:  return {24'h0, b};
         3'b001:  return 32'(h);
         3'b101:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((bus.MemOP[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.MemOP[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // cnt holds cycles since accept (the accept cycle counts as 1), so the
   // response lands exactly TIMEOUT_CYCLES cycles after accept
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt) + 32'd1) >= TIMEOUT_CYCLES);
   assign rsp_data    = (!we_r && !bus.mem_err) ? load_extract(op_r, off_r, bus.mem_rdata) : '0;

   always_ff @(posedge clk) begin
      if (accept) begin
         op_r  <= bus.MemOP;
         off_r <= bus.addr[1:0];
         we_r  <= bus.MemWr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cnt            <= '0;
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.rdata      <= '0;
         bus.err        <= 1'b0;
         bus.mem_req    <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_wmask  <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.req_ready <= 1'b1;
               cnt           <= '0;
               if (accept) begin
                  bus.req_ready <= 1'b0;
                  if (!op_legal(bus.MemOP) || misalign) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.err        <= 1'b1;
                     bus.rdata      <= '0;
                  end else begin
                     state         <= REQ;
                     cnt           <= CNT_W'(1);
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= bus.MemWr;
                     bus.mem_addr  <= {bus.addr[31:2], 2'b00};
                     bus.mem_wdata <= lane_data(bus.MemOP[1:0], bus.wdata);
                     bus.mem_wmask <= bus.MemWr ? byte_mask(bus.MemOP[1:0], bus.addr[1:0]) : 4'b0000;
                  end
               end
            end
            REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (bus.mem_gnt && bus.mem_rvalid) begin
                  state          <= RESP;
                  bus.mem_req    <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.err        <= bus.mem_err;
                  bus.rdata      <= rsp_data;
               end else if (timeout_hit) begin
                  state          <= RESP;
                  bus.mem_req    <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  bus.err        <= 1'b1;
                  bus.rdata      <= '0;
               end else if (bus.mem_gnt) begin
                  state       <= WAIT;
                  bus.mem_req <= 1'b0;
               end
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (bus.mem_rvalid) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.err        <= bus.mem_err;
                  bus.rdata      <= rsp_data;
               end else if (timeout_hit) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.err        <= 1'b1;
                  bus.rdata      <= '0;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state          <= IDLE;
                  bus.resp_valid <= 1'b0;
                  bus.err        <= 1'b0;
                  bus.rdata      <= '0;
                  bus.req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed and random transactions, bus-side checks in the driver,
// response checks in an independent monitor.
module tb_lsu;
   localparam int TO = 8;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   lsu_if bus ();

   lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t exp_q[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic bit legal(input logic [2:0] op);
      return op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   endfunction

   function automatic int size_bytes(input logic [2:0] op);
      if (op[1:0] == 2'b00) return 1;
      if (op[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit trap(input logic [2:0] op, input logic [31:0] a);
      return TRAP_ON && ((int'(a[1:0]) % size_bytes(op)) != 0);
   endfunction

   function automatic logic [3:0] model_mask(input bit we, input logic [2:0] op, input logic [31:0] a);
      int n, base;
      if (!we) return 4'b0000;
      n    = size_bytes(op);
      base = (int'(a[1:0]) / n) * n;
      return 4'(((1 << n) - 1) << base);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
      case (size_bytes(op))
         1:       return 32'(w[7:0]) * 32'h0101_0101;
         2:       return 32'(w[15:0]) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] word);
      longint v;
      int     n, base;
      n    = size_bytes(op);
      base = (int'(a[1:0]) / n) * n;
      v    = longint'(word >> (8 * base));
      if (n < 4) v = v % (longint'(1) << (8 * n));
      if (n < 4 && !op[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic txn(input logic [31:0] a, input logic [31:0] wd, input bit we,
                      input logic [2:0] op, input int g, input int r,
                      input logic [31:0] word, input bit merr, input bit stray);
      exp_t e;
      int   acc, c, waitc;
      bit   bus_op;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.addr      = a;
      bus.wdata     = wd;
      bus.MemWr     = we;
      bus.MemOP     = op;
      waitc         = 0;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         waitc++;
         if (waitc > 300) begin
            $display("FAIL req_ready_timeout: req_ready stayed 0 for %0d cycles", waitc);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
            $fatal(1);
         end
      end
      acc    = cyc;
      bus_op = legal(op) && !trap(op, a);
      c      = 1 + g + r;
      if (!bus_op) begin
         e.err = 1'b1; e.rdata = '0; e.due = acc + 1;
      end else if (c <= TO - 1) begin
         e.err   = merr;
         e.rdata = (we || merr) ? 32'h0 : model_load(op, a, word);
         e.due   = acc + c + 1;
      end else begin
         e.err = 1'b1; e.rdata = '0; e.due = acc + TO;
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.addr      = $urandom;
      bus.wdata     = $urandom;
      bus.MemOP     = 3'($urandom_range(7));
      bus.MemWr     = 1'($urandom_range(1));
      if (!bus_op) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("no_mem_req_on_reject", 32'(bus.mem_req), 32'h0);
            @(posedge clk); #1;
         end
         return;
      end
      for (int k = 1; k <= c; k++) begin
         bus.mem_gnt    = (k == 1 + g);
         bus.mem_rvalid = (k == c) || (stray && k < 1 + g && $urandom_range(1) == 1);
         bus.mem_rdata  = (k == c) ? word : $urandom;
         bus.mem_err    = (k == c) ? merr : 1'($urandom_range(1));
         @(negedge clk);
         if (k <= TO - 1) begin
            if (k <= 1 + g) begin
               check("mem_req_held", 32'(bus.mem_req), 32'h1);
               check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
               check("mem_we", 32'(bus.mem_we), 32'(we));
               check("mem_wmask", 32'(bus.mem_wmask), 32'(model_mask(we, op, a)));
               if (we) check("mem_wdata", bus.mem_wdata, model_wdata(op, wd));
            end else begin
               check("mem_req_after_gnt", 32'(bus.mem_req), 32'h0);
            end
         end
         @(posedge clk); #1;
      end
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
   endtask

   // response-side scoreboard monitor
   initial begin
      exp_t cur;
      bit   active;
      active = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            active = 1'b0;
         end else if (bus.resp_valid) begin
            if (!active) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL resp_unexpected: resp_valid=1 rdata=%08h err=%0b with nothing outstanding",
                           bus.rdata, bus.err);
               end else begin
                  cur    = exp_q.pop_front();
                  active = 1'b1;
                  check("resp_cycle", 32'(cyc), 32'(cur.due));
               end
            end
            if (active) begin
               check("resp_rdata", bus.rdata, cur.rdata);
               check("resp_err", 32'(bus.err), 32'(cur.err));
               check("req_ready_in_resp", 32'(bus.req_ready), 32'h0);
            end
            if (bus.resp_ready) active = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         bus.resp_ready = ($urandom_range(3) != 0);
      end
   end

   initial begin
      logic [31:0] a, wd, word;
      logic [2:0]  op;
      logic [2:0]  illegal_tab[3] = '{3'd3, 3'd6, 3'd7};
      logic [2:0]  load_tab[5]    = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      bit          we, merr;
      int          g, r, drain;
      bus.req_valid  = 1'b0;
      bus.addr       = '0;
      bus.wdata      = '0;
      bus.MemWr      = 1'b0;
      bus.MemOP      = '0;
      bus.resp_ready = 1'b0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      bus.mem_err    = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      check("rst_mem_req", 32'(bus.mem_req), 32'h0);
      check("rst_mem_we", 32'(bus.mem_we), 32'h0);
      check("rst_mem_addr", bus.mem_addr, 32'h0);
      check("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      // directed cases
      txn(32'h8000_0104, 32'hDEAD_BEEF, 1'b1, 3'b010, 0, 2, 32'h0, 1'b0, 1'b0);
      txn(32'h8000_0103, 32'h0, 1'b0, 3'b000, 0, 1, 32'h80A1_B2C3, 1'b0, 1'b0);
      txn(32'h8000_0103, 32'h0, 1'b0, 3'b100, 1, 0, 32'h80A1_B2C3, 1'b0, 1'b0);
      txn(32'h8000_0102, 32'h0, 1'b0, 3'b001, 0, 0, 32'h7FFF_0000, 1'b0, 1'b0);
      txn(32'h8000_0102, 32'h1234_BEEF, 1'b1, 3'b001, 0, 1, 32'h0, 1'b0, 1'b0);
      txn(32'h8000_0100, 32'h0, 1'b0, 3'b101, 0, 0, 32'h8001_F00D, 1'b0, 1'b0);
      txn(32'h8000_0200, 32'h0, 1'b0, 3'b010, 5, 1, 32'hCAFE_F00D, 1'b0, 1'b1);
      txn(32'h8000_0300, 32'h0, 1'b0, 3'b010, 0, 12, 32'h1111_2222, 1'b0, 1'b0);
      txn(32'h8000_0300, 32'h5555_AAAA, 1'b1, 3'b000, 9, 0, 32'h0, 1'b0, 1'b0);
      txn(32'h8000_0102, 32'hA5A5_5A5A, 1'b1, 3'b010, 0, 1, 32'h0, 1'b0, 1'b0);
      txn(32'h8000_0101, 32'h0, 1'b0, 3'b001, 0, 1, 32'h89AB_CDEF, 1'b0, 1'b0);
      txn(32'h8000_0400, 32'h0, 1'b0, 3'b011, 0, 0, 32'h0, 1'b0, 1'b0);
      txn(32'h8000_0400, 32'h0, 1'b1, 3'b111, 0, 0, 32'h0, 1'b0, 1'b0);
      txn(32'h8000_0500, 32'h0, 1'b0, 3'b010, 1, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);

      for (int i = 0; i < 160; i++) begin
         a    = $urandom;
         wd   = $urandom;
         word = $urandom;
         we   = 1'($urandom_range(1));
         if ($urandom_range(9) == 0) op = illegal_tab[$urandom_range(2)];
         else if (we)                op = 3'($urandom_range(2));
         else                        op = load_tab[$urandom_range(4)];
         g    = $urandom_range(4);
         r    = ($urandom_range(9) == 0) ? $urandom_range(9, 4) : $urandom_range(3);
         merr = ($urandom_range(7) == 0);
         txn(a, wd, we, op, g, r, word, merr, 1'($urandom_range(1)));
      end

      drain = 0;
      while ((exp_q.size() != 0 || bus.resp_valid) && drain < 200) begin
         @(negedge clk);
         drain++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      // asynchronous reset while a request is waiting for grant
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.addr      = 32'h8000_0800;
      bus.MemWr     = 1'b0;
      bus.MemOP     = 3'b010;
      drain         = 0;
      do begin
         @(negedge clk);
         drain++;
      end while (!bus.req_ready && drain < 50);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_mem_req", 32'(bus.mem_req), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_mem_req", 32'(bus.mem_req), 32'h0);
      check("async_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check("async_rst_req_ready", 32'(bus.req_ready), 32'h0);
      @(posedge clk); #1;
      rst            = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_0001;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("stray_rvalid_no_resp", 32'(bus.resp_valid), 32'h0);
      end
      check("idle_req_ready", 32'(bus.req_ready), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit: the memory-access stage directly downstream of the ALU.
- Consumes the ALU result as the effective address, plus the store data register operand, MemWr and MemOP from the control-signal generator.
- Returns sign/zero-extended load data for GPR writeback on the MemtoReg path.
- Talks to data memory over a simple request/grant/response bus with variable latency, so the core must stall while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles from request acceptance to mem_rvalid before a bus error is reported; 0 disables the timeout.
- CNT_W, 9: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  core presents a memory op
- req_ready  output  1  LSU can accept an op
- addr  input  32  effective byte address
- wdata  input  32  store data, right-aligned
- MemWr  input  1  1 = store, 0 = load
- MemOP  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes illegal
- resp_valid  output  1  result available
- resp_ready  input  1  core consumes result
- rdata  output  32  extended load data; 0 for stores and errors
- err  output  1  bus error, timeout or illegal op (with resp_valid)
- mem_req  output  1  bus request
- mem_we  output  1  bus write enable
- mem_addr  output  32  word-aligned address (addr[1:0] forced to 00)
- mem_wdata  output  32  lane-shifted store data
- mem_wmask  output  4  byte strobes
- mem_gnt  input  1  bus accepts request this cycle
- mem_rvalid  input  1  read data / write ack
- mem_rdata  input  32  word read data
- mem_err  input  1  bus error, qualified by mem_rvalid

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0. All outputs 0, including req_ready. A captured transaction is discarded and mem_req drops immediately.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch addr, wdata, MemWr, MemOP.
  - Next state is REQ, or RESP with err=1 if MemOP is illegal (no bus activity).
- REQ:
  - mem_req=1; mem_we/addr/wdata/wmask are held stable from latched values until mem_gnt.
  - mem_gnt=1: go to WAIT. If mem_rvalid is also 1 in the same cycle, go straight to RESP.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, go to RESP.
  - For loads, register the extracted, extended data; err=mem_err.
- RESP:
  - resp_valid=1; rdata and err held until resp_ready=1, then IDLE.
  - req_ready is 0 in RESP, so there is no back-to-back accept.
  - Minimum latency, accept to resp_valid: 2 cycles (gnt and rvalid in the same REQ cycle).
- Byte lanes, o = addr[1:0]:
  - B: wmask = 0001<<o; mem_wdata = {4{wdata[7:0]}}.
  - H: wmask = 0011<<{o[1],0}; mem_wdata = {2{wdata[15:0]}}.
  - W: wmask = 1111; mem_wdata = wdata.
  - Loads: wmask = 0000, mem_we = 0.
- Load extract:
  - Select the byte at o, or the halfword at o[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Timeout:
  - Counter increments each cycle in REQ or WAIT and clears on entry to IDLE.
  - Reaching TIMEOUT_CYCLES goes to RESP with err=1, rdata=0.
  - A late mem_rvalid arriving in RESP or IDLE is ignored.
- mem_rvalid arriving in REQ without mem_gnt is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: H with addr[0]=1, or W with addr[1:0]!=00, is rejected in IDLE. Goes to RESP next cycle with err=1, rdata=0, and no mem_req.
- Undefined: misalignment is not checked. H ignores addr[0]; W ignores addr[1:0]. The access proceeds to the aligned location.

Test Plan:
- Store word: addr=0x80000104, wdata=0xDEADBEEF, MemOP=010, gnt on first REQ cycle, rvalid 2 cycles later -> mem_addr=0x80000104, wmask=1111, mem_we=1; resp_valid with err=0, rdata=0.
- Load byte signed: addr=0x80000103, MemOP=000, mem_rdata=0x80A1B2C3 -> rdata=0xFFFFFF80. Same access with MemOP=100 -> rdata=0x00000080.
- Load halfword: addr=0x80000102, MemOP=001, mem_rdata=0x7FFF0000 -> rdata=0x00007FFF, mem_addr=0x80000100. Store half at the same address -> wmask=1100, mem_wdata=0xBEEFBEEF for wdata=0x1234BEEF.
- Backpressure/timeout:
  - mem_gnt held 0 for 5 cycles -> mem_req and address stable all 5 cycles.
  - With TIMEOUT_CYCLES=8 and no rvalid -> resp_valid, err=1 exactly 8 cycles after accept.
  - resp_ready held 0 for 3 cycles -> rdata/err stable, req_ready=0.
- Reset mid-operation: assert rst=0 while in WAIT -> mem_req, resp_valid, req_ready go 0 asynchronously. After release, IDLE; a stray mem_rvalid produces no resp_valid.
- Misaligned word at addr=0x80000102:
  - LSU_MISALIGN_TRAP_EN defined -> err=1, no mem_req.
  - Undefined -> mem_req issued at 0x80000100 with wmask=1111.
